// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and sizes for the round-robin arbiter
package arb_pkg;

  localparam int NUM_REQ = 32;
  localparam int ID_W    = 5;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - 32-bit lowest-index-first priority encoder
module priority_encoder
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  output req_id_t            idx_o,
  output logic               valid_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = req_id_t'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - 32-client round-robin arbiter with done/drop/hold-limit release
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic                done_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_W-1:0]     gnt_id_o,
  output logic                gnt_valid_o,
  output logic                timeout_o
);

  // Last cycle index of a grant; hold_cnt never passes it, so it cannot wrap.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  arb_state_t         state_q, state_d;
  req_id_t            last_id_q, last_id_d;
  req_id_t            gnt_id_q, gnt_id_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;

  logic [5:0]         shift_amt;
  logic [NUM_REQ-1:0] above_mask;
  req_id_t            above_idx, any_idx, winner;
  logic               above_valid, any_valid;
  logic               owner_req, hit_limit, release_now;

  // Six-bit shift so last_id=31 shifts by 32 and leaves an empty mask.
  assign shift_amt  = {1'b0, last_id_q} + 6'd1;
  assign above_mask = {NUM_REQ{1'b1}} << shift_amt;

  priority_encoder u_enc_above (
    .req_i   (req_i & above_mask),
    .idx_o   (above_idx),
    .valid_o (above_valid)
  );

  priority_encoder u_enc_any (
    .req_i   (req_i),
    .idx_o   (any_idx),
    .valid_o (any_valid)
  );

  assign winner      = above_valid ? above_idx : any_idx;
  assign owner_req   = req_i[gnt_id_q];
  assign hit_limit   = (hold_cnt_q == HOLD_LAST);
  assign release_now = done_i || !owner_req || hit_limit;

  // Next-state logic: grant from IDLE, release or count hold cycles in BUSY.
  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    gnt_id_d    = gnt_id_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d     = BUSY;
          last_id_d   = winner;
          gnt_id_d    = winner;
          gnt_d       = NUM_REQ'(1) << winner;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          // Only a pure hold-limit expiry counts as a timeout.
          timeout_d   = hit_limit && !done_i && owner_req;
        end else begin
          hold_cnt_d  = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset parks the rotation pointer at 31 so search starts at 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_id_q   <= req_id_t'(NUM_REQ - 1);
      gnt_id_q    <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      gnt_id_q    <= gnt_id_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign gnt_valid_o = gnt_valid_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking bench for rr_arbiter
module tb_rr_arbiter;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] req_i;
  logic        done_i;
  logic [31:0] gnt_o;
  logic [4:0]  gnt_id_o;
  logic        gnt_valid_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .done_i      (done_i),
    .gnt_o       (gnt_o),
    .gnt_id_o    (gnt_id_o),
    .gnt_valid_o (gnt_valid_o),
    .timeout_o   (timeout_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: owner index (-1 = none), rotation pointer, cycles held.
  int m_owner = -1;
  int m_last  = 31;
  int m_cnt   = 0;
  bit m_to    = 1'b0;
  bit chk_en  = 1'b0;

  always @(posedge clk) begin
    bit dropped, lim;
    int idx;
    if (rst_i) begin
      m_owner = -1;
      m_last  = 31;
      m_cnt   = 0;
      m_to    = 1'b0;
      chk_en  = 1'b1;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        if (req_i != 0) begin
          for (int k = 1; k <= 32; k++) begin
            idx = (m_last + k) % 32;
            if (req_i[idx]) begin
              m_owner = idx;
              m_last  = idx;
              m_cnt   = 0;
              break;
            end
          end
        end
      end else begin
        dropped = !req_i[m_owner];
        lim     = (m_cnt == HOLD - 1);
        if (done_i || dropped || lim) begin
          m_to    = lim && !done_i && !dropped;
          m_owner = -1;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle after the first reset.
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt_valid_o", 32'(gnt_valid_o), 32'(m_owner >= 0));
      check("gnt_o", gnt_o, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("timeout_o", 32'(timeout_o), 32'(m_to));
      if (m_owner >= 0) check("gnt_id_o", 32'(gnt_id_o), 32'(m_owner));
    end
  end

  // Observer: grant ids, lengths, idle gaps, timeout pulses, one-hot violations.
  int obs_ids[$];
  int obs_lens[$];
  int obs_gaps[$];
  int cur_len, gap_cnt, to_cnt, onehot_bad;
  bit prev_valid, seen_end;

  always @(negedge clk) begin
    if (gnt_valid_o === 1'b1) begin
      if ($countones(gnt_o) != 1) onehot_bad++;
      if (!prev_valid) begin
        if (seen_end) obs_gaps.push_back(gap_cnt);
        obs_ids.push_back(int'(gnt_id_o));
        cur_len = 1;
      end else begin
        cur_len++;
      end
    end else begin
      if (prev_valid) begin
        obs_lens.push_back(cur_len);
        gap_cnt  = 1;
        seen_end = 1'b1;
      end else begin
        gap_cnt++;
      end
    end
    if (timeout_o === 1'b1) to_cnt++;
    prev_valid = (gnt_valid_o === 1'b1);
  end

  task automatic clear_logs();
    obs_ids.delete();
    obs_lens.delete();
    obs_gaps.delete();
    cur_len    = 0;
    gap_cnt    = 0;
    to_cnt     = 0;
    onehot_bad = 0;
    prev_valid = 1'b0;
    seen_end   = 1'b0;
  endtask

  // 0: never done, 1: done on 2nd grant cycle, 2: done on every grant cycle
  int done_mode = 0;

  task automatic step();
    @(posedge clk);
    #1;
    case (done_mode)
      1:       done_i = (m_owner >= 0) && (m_cnt == 1);
      2:       done_i = (m_owner >= 0);
      default: done_i = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    clear_logs();
  endtask

  task automatic wait_grants(input string name, input int n, input int budget);
    for (int c = 0; c < budget && obs_ids.size() < n; c++) step();
    check({name, " grant count"}, 32'(obs_ids.size() >= n), 32'd1);
  endtask

  task automatic idle_out(input int n);
    req_i     = '0;
    done_mode = 0;
    done_i    = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_i  = 1'b1;
    req_i  = '0;
    done_i = 1'b0;
    clear_logs();

    // Reset values and a quiet bus
    do_reset();
    check("rst gnt_valid_o", 32'(gnt_valid_o), 32'd0);
    check("rst gnt_o", gnt_o, 32'd0);
    check("rst gnt_id_o", 32'(gnt_id_o), 32'd0);
    check("rst timeout_o", 32'(timeout_o), 32'd0);
    for (int i = 0; i < 10; i++) step();
    check("quiet grants", 32'(obs_ids.size()), 32'd0);

    // Two clients alternate, each releasing on its 2nd grant cycle
    clear_logs();
    req_i     = 32'h0000_0005;
    done_mode = 1;
    wait_grants("alt", 4, 60);
    step(); step(); step();
    idle_out(3);
    check("alt id0", 32'(obs_ids[0]), 32'd0);
    check("alt id1", 32'(obs_ids[1]), 32'd2);
    check("alt id2", 32'(obs_ids[2]), 32'd0);
    check("alt id3", 32'(obs_ids[3]), 32'd2);
    for (int i = 0; i < 4; i++) check("alt len", 32'(obs_lens[i]), 32'd2);
    for (int i = 0; i < 3; i++) check("alt gap", 32'(obs_gaps[i]), 32'd1);

    // Full sweep 0..31 then wrap to 0
    do_reset();
    req_i     = 32'hFFFF_FFFF;
    done_mode = 2;
    wait_grants("sweep", 33, 120);
    idle_out(3);
    for (int i = 0; i < 33; i++) check("sweep id", 32'(obs_ids[i]), 32'(i % 32));
    check("sweep onehot", 32'(onehot_bad), 32'd0);
    check("sweep len", 32'(obs_lens[0]), 32'd1);
    check("sweep gap", 32'(obs_gaps[0]), 32'd1);

    // Hold limit on client 31
    do_reset();
    req_i     = 32'h8000_0000;
    done_mode = 0;
    wait_grants("hold", 2, 30);
    check("hold id0", 32'(obs_ids[0]), 32'd31);
    check("hold id1", 32'(obs_ids[1]), 32'd31);
    check("hold len", 32'(obs_lens[0]), 32'(HOLD));
    check("hold gap", 32'(obs_gaps[0]), 32'd1);
    check("hold timeouts", 32'(to_cnt), 32'd1);
    idle_out(6);

    // Owner 3 drops its request on its 2nd cycle, pending 7 follows
    do_reset();
    req_i = 32'h0000_0088;
    step();
    check("drop first owner", 32'(gnt_id_o), 32'd3);
    step();
    req_i = 32'h0000_0080;
    step();
    check("drop released", 32'(gnt_valid_o), 32'd0);
    wait_grants("drop", 2, 10);
    check("drop id0", 32'(obs_ids[0]), 32'd3);
    check("drop id1", 32'(obs_ids[1]), 32'd7);
    check("drop len", 32'(obs_lens[0]), 32'd2);
    check("drop gap", 32'(obs_gaps[0]), 32'd1);
    check("drop timeouts", 32'(to_cnt), 32'd0);
    idle_out(6);

    // Reset mid-grant to client 20, rotation restarts at 0
    do_reset();
    req_i = 32'h0010_0000;
    step();
    step();
    check("rst20 owner", 32'(gnt_id_o), 32'd20);
    req_i = 32'h0010_0001;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rst20 dropped", 32'(gnt_valid_o), 32'd0);
    clear_logs();
    done_mode = 2;
    wait_grants("rst20", 2, 20);
    check("rst20 id0", 32'(obs_ids[0]), 32'd0);
    check("rst20 id1", 32'(obs_ids[1]), 32'd20);
    idle_out(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

32-requester round-robin arbiter that owns a shared resource on behalf of up to 32 clients and hands it to one client at a time. Each grant is held until the owner signals done, drops its request, or exceeds a hold limit. Selection is built from two instances of the existing 32-bit `priority_encoder`: one searches requests above the last winner and one searches all requests. The block sits in front of any single-ported resource, such as a bus, memory port, or execution unit.

## Interface
- `HOLD_MAX`, 16: maximum cycles a grant may be held; range 1..255.
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_i`  in  32  request vector; bit n = client n requests.
- `done_i`  in  1  current owner releases the resource this cycle.
- `gnt_o`  out  32  one-hot grant vector; all zero when idle.
- `gnt_id_o`  out  5  index of current owner; valid only when `gnt_valid_o`=1.
- `gnt_valid_o`  out  1  a grant is active.
- `timeout_o`  out  1  one-cycle pulse when a grant is revoked by `HOLD_MAX`.

## Operation
- State machine with two states, IDLE and BUSY.
- IDLE:
  - If `req_i`≠0, select the winner, register it, and go to BUSY.
  - Otherwise stay in IDLE.
- Winner selection:
  - `above_mask` = ones in bit positions strictly greater than `last_id`. Compute the shift in 6 bits so that `last_id`=31 gives an all-zero mask.
  - Encoder A takes `req_i & above_mask`. Encoder B takes `req_i`.
  - If A is valid the winner is A's output; otherwise the winner is B's output.
- On grant:
  - `last_id` ← winner; `gnt_id_o` ← winner; `gnt_o` ← 1<<winner; `gnt_valid_o` ← 1.
  - `hold_cnt` ← 0.
- BUSY, release condition (any of):
  - `done_i`=1;
  - `req_i[gnt_id_o]`=0;
  - `hold_cnt`=`HOLD_MAX`-1.
- On release:
  - Next state is IDLE; `gnt_o` ← 0; `gnt_valid_o` ← 0.
  - `timeout_o` ← 1 for one cycle only when the hold limit was the sole cause. If `done_i` or a dropped request coincides with the limit, it is a normal release and `timeout_o` stays 0.
- BUSY, no release: `hold_cnt` increments. `hold_cnt` saturates by construction and never wraps.
- There is no regrant in the release cycle. Every release is followed by exactly one IDLE cycle before the next grant.
- Requests from non-owners while BUSY are ignored and do not need to be held stable; they are sampled only in IDLE.
- `done_i` while IDLE has no effect.

## Timing
- Reset, effective at the first rising edge with `rst_i`=1:
  - State = IDLE; `last_id`=31, so the first search starts at bit 0.
  - `gnt_o`=0, `gnt_id_o`=0, `gnt_valid_o`=0, `timeout_o`=0, `hold_cnt`=0.
- Reset mid-grant drops the grant in the same edge. The rotation pointer also returns to 31.
- Grant latency: a request seen in IDLE at edge k gives `gnt_o` valid after edge k.
- Release latency: a release condition seen at edge k gives `gnt_o`=0 after edge k.
- Minimum grant length is 1 cycle; maximum is `HOLD_MAX` cycles.
- Back-to-back service cost: grant + 1 IDLE cycle.
- All outputs are registered. There is no combinational path from `req_i` or `done_i` to any output.

## Structure
- Package `arb_pkg`:
  - `localparam NUM_REQ=32`, `ID_W=5`.
  - `typedef enum logic {IDLE, BUSY} arb_state_t`.
  - `typedef logic [ID_W-1:0] req_id_t`.
- Sub-module: two instances of `priority_encoder` (masked and unmasked search). No new sub-module.
- Target size is about 150 lines of RTL.

## Test plan
- Reset, then `req_i`=0 for 10 cycles -> `gnt_valid_o`=0, `gnt_o`=0 throughout.
- `req_i`=0x0000_0005, each owner asserts `done_i` on its 2nd grant cycle -> grant order 0, 2, 0, 2 with `gnt_id_o` 0/2. Each grant is 2 cycles with 1 idle cycle between grants.
- `req_i`=0xFFFF_FFFF, `done_i`=1 on every grant cycle -> `gnt_id_o` visits 0, 1, …, 31, then wraps to 0. `gnt_o` is one-hot each time.
- `HOLD_MAX`=4, `req_i`=0x8000_0000 held, `done_i`=0 -> grant to 31 for exactly 4 cycles, `timeout_o` pulses once, 1 idle cycle, then regrant to 31.
- Owner 3 granted, then `req_i[3]` deasserted in cycle 2 -> `gnt_o`=0 on the next cycle, `timeout_o`=0. Pending `req_i[7]` is granted after 1 idle cycle.
- `rst_i` asserted while client 20 is granted, `req_i`=0x0010_0001 after reset -> grant goes to 0 first, then 20.
